// File: rtl/bram_pkg.sv
// Shared types and limits for the dual-port BRAM responder.
package bram_pkg;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        DUMP
    } state_t;

    localparam int unsigned MAX_READ_LATENCY = 4;

endpackage

// File: rtl/bram_read_pipe.sv
// Read-data delay line: {valid, data} shifts LATENCY stages; the output holds its
// last value whenever no read completes.
module bram_read_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] out_q;

    generate
        if (LATENCY <= 1) begin : g_direct
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else if (valid_i) begin
                    out_q <= data_i;
                end
            end
        end else begin : g_shift
            logic                  v_q [LATENCY-1];
            logic [DATA_WIDTH-1:0] d_q [LATENCY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                        v_q[i] <= 1'b0;
                        d_q[i] <= '0;
                    end
                    out_q <= '0;
                end else begin
                    v_q[0] <= valid_i;
                    d_q[0] <= data_i;
                    for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                    // Final stage doubles as the hold register for din.
                    if (v_q[LATENCY-2]) begin
                        out_q <= d_q[LATENCY-2];
                    end
                end
            end
        end
    endgenerate

    assign data_o = out_q;

endmodule

// File: rtl/bram_responder.sv
// Dual-port BRAM responder with read-first collisions, out-of-range detection,
// and a streaming preload/dump side channel driven by a RUN/LOAD/DUMP FSM.
module bram_responder
    import bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic                  ce1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] din1,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  dump_start,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  busy,
    output logic                  oob_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned LAT   = (READ_LATENCY < 1) ? 1 :
                                    (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                    READ_LATENCY;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q;
    logic [PTR_W-1:0]      ptr_q;
    logic                  load_ready_q;
    logic                  dump_valid_q;
    logic [DATA_WIDTH-1:0] dump_data_q;
    logic                  busy_q;
    logic                  oob_q;

    logic                  run;
    logic [IDX_W-1:0]      idx0, idx1;
    logic                  oob0, oob1;
    logic                  acc0, acc1;
    logic                  rd0, rd1, wr0, wr1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  load_wr;

    always_comb begin
        run     = (state_q == RUN);
        idx0    = address0[IDX_W-1:0];
        idx1    = address1[IDX_W-1:0];
        oob0    = (address0 >> IDX_W) != '0;
        oob1    = (address1 >> IDX_W) != '0;
        acc0    = run && ce0;
        acc1    = run && ce1;
        rd0     = acc0 && !we0;
        rd1     = acc1 && !we1;
        wr0     = acc0 && we0 && !oob0;
        wr1     = acc1 && we1 && !oob1;
        rdata0  = (rd0 && !oob0) ? mem[idx0] : '0;
        rdata1  = (rd1 && !oob1) ? mem[idx1] : '0;
        load_wr = (state_q == LOAD) && load_valid;
    end

    // Reads sample the array before this edge's writes land, giving read-first
    // collisions; port 1 is written last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[ptr_q[IDX_W-1:0]] <= load_data;
        end
        if (wr0) begin
            mem[idx0] <= dout0;
        end
        if (wr1) begin
            mem[idx1] <= dout1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            ptr_q        <= '0;
            load_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            busy_q       <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            if ((acc0 && oob0) || (acc1 && oob1)) begin
                oob_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (load_start) begin
                        state_q      <= LOAD;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        ptr_q        <= '0;
                    end else if (dump_start) begin
                        state_q <= DUMP;
                        busy_q  <= 1'b1;
                        ptr_q   <= '0;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        if (ptr_q == PTR_W'(DEPTH - 1)) begin
                            state_q      <= RUN;
                            load_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            ptr_q        <= '0;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                DUMP: begin
                    // ptr_q counts words already fetched; DEPTH means the last one is on display.
                    if (!dump_valid_q) begin
                        dump_data_q  <= mem[ptr_q[IDX_W-1:0]];
                        dump_valid_q <= 1'b1;
                        ptr_q        <= ptr_q + 1'b1;
                    end else if (dump_ready) begin
                        if (ptr_q == PTR_W'(DEPTH)) begin
                            state_q      <= RUN;
                            dump_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            ptr_q        <= '0;
                        end else begin
                            dump_data_q <= mem[ptr_q[IDX_W-1:0]];
                            ptr_q       <= ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    bram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LAT)
    ) u_pipe0 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd0),
        .data_i  (rdata0),
        .data_o  (din0)
    );

    bram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LAT)
    ) u_pipe1 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd1),
        .data_i  (rdata1),
        .data_o  (din1)
    );

    assign load_ready = load_ready_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign busy       = busy_q;
    assign oob_err    = oob_q;

endmodule

// File: tb/tb_bram_responder.sv
// Scoreboard bench: two responders (read latency 1 and 3) share one stimulus stream
// and are checked against an array-based reference memory.
module tb_bram_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce0, we0, ce1, we1;
    logic [AW-1:0] address0, address1;
    logic [DW-1:0] dout0, dout1;
    logic          load_start, load_valid, dump_start, dump_ready;
    logic [DW-1:0] load_data;

    logic [DW-1:0] din0_a, din1_a, dump_data_a, din0_b, din1_b, dump_data_b;
    logic          load_ready_a, dump_valid_a, busy_a, oob_a;
    logic          load_ready_b, dump_valid_b, busy_b, oob_b;

    always #5 clk = ~clk;

    bram_responder #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (1)
    ) u_lat1 (
        .clk        (clk),
        .rst        (rst),
        .ce0        (ce0),
        .we0        (we0),
        .address0   (address0),
        .dout0      (dout0),
        .din0       (din0_a),
        .ce1        (ce1),
        .we1        (we1),
        .address1   (address1),
        .dout1      (dout1),
        .din1       (din1_a),
        .load_start (load_start),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready_a),
        .dump_start (dump_start),
        .dump_data  (dump_data_a),
        .dump_valid (dump_valid_a),
        .dump_ready (dump_ready),
        .busy       (busy_a),
        .oob_err    (oob_a)
    );

    bram_responder #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (3)
    ) u_lat3 (
        .clk        (clk),
        .rst        (rst),
        .ce0        (ce0),
        .we0        (we0),
        .address0   (address0),
        .dout0      (dout0),
        .din0       (din0_b),
        .ce1        (ce1),
        .we1        (we1),
        .address1   (address1),
        .dout1      (dout1),
        .din1       (din1_b),
        .load_start (load_start),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready_b),
        .dump_start (dump_start),
        .dump_data  (dump_data_b),
        .dump_valid (dump_valid_b),
        .dump_ready (dump_ready),
        .busy       (busy_b),
        .oob_err    (oob_b)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned edges  = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          oob_exp;
    bit          model_run;
    exp_t        pq [4][$];
    logic [31:0] dq [$];
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data;
    string       pname [4] = '{"din0_lat1", "din1_lat1", "din0_lat3", "din1_lat3"};

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_read(input int p, input int unsigned a);
        exp_t e;
        e.data = (a < DEPTH) ? ref_mem[a % DEPTH] : 32'h0;
        e.due  = edges + 1;
        pq[p].push_back(e);
        e.due  = edges + 3;
        pq[p+2].push_back(e);
    endtask

    // One bus cycle on both ports; model reads see memory before this cycle's writes.
    task automatic port_cycle(input bit c0, input bit w0, input int unsigned a0, input logic [31:0] d0,
                              input bit c1, input bit w1, input int unsigned a1, input logic [31:0] d1);
        ce0 = c0; we0 = w0; address0 = a0[AW-1:0]; dout0 = d0;
        ce1 = c1; we1 = w1; address1 = a1[AW-1:0]; dout1 = d1;
        if (model_run) begin
            if (c0 && !w0) push_read(0, a0);
            if (c1 && !w1) push_read(1, a1);
            if ((c0 && a0 >= DEPTH) || (c1 && a1 >= DEPTH)) oob_exp = 1'b1;
            if (c0 && w0 && a0 < DEPTH) ref_mem[a0 % DEPTH] = d0;
            if (c1 && w1 && a1 < DEPTH) ref_mem[a1 % DEPTH] = d1;
        end
        @(posedge clk); #1;
        ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) port_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_traffic(input int n);
        int unsigned a0, a1;
        for (int i = 0; i < n; i++) begin
            a0 = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, DEPTH - 1);
            a1 = ($urandom_range(0, 2) == 0) ? a0 :
                 (($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, DEPTH - 1));
            port_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a0, $urandom,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a1, $urandom);
        end
    endtask

    task automatic do_load(input bit rnd);
        int          k = 0;
        int          it = 0;
        int          busy_cnt = 0;
        logic [31:0] v;
        bit          acc;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        model_run  = 1'b0;
        while (k < DEPTH && it < 200) begin
            v          = rnd ? $urandom : 32'(k * 3);
            load_data  = v;
            load_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            acc = load_valid && load_ready_a;
            if (busy_a) busy_cnt++;
            @(posedge clk); #1;
            it++;
            if (acc) begin
                ref_mem[k] = v;
                k++;
            end
        end
        load_valid = 1'b0;
        chk("load_words", k, DEPTH);
        chk("load_busy_fall_lat1", busy_a, 0);
        chk("load_busy_fall_lat3", busy_b, 0);
        chk("load_ready_fall", load_ready_a, 0);
        if (!rnd) chk("load_busy_cycles", busy_cnt, 16);
        model_run = 1'b1;
    endtask

    // mode 0: ready alternates; mode 1: random ready, reset mid-dump; mode 2: ready held, ports poked.
    task automatic do_dump(input int mode);
        int it = 0;
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        model_run  = 1'b0;
        chk("dump_busy_rise", busy_a, 1);
        for (int k = 0; k < DEPTH; k++) dq.push_back(ref_mem[k]);
        while (dq.size() > 0 && it < 200) begin
            case (mode)
                0:       dump_ready = (it % 2 == 0);
                1:       dump_ready = $urandom_range(0, 1) != 0;
                default: dump_ready = 1'b1;
            endcase
            if (mode == 2) begin
                ce1 = 1'b1; we1 = 1'b1; address1 = 12'd3; dout1 = 32'hDEAD_BEEF;
                ce0 = 1'b1; we0 = 1'b1; address0 = 12'd200; dout0 = 32'h0BAD_0BAD;
            end
            @(posedge clk); #1;
            it++;
            if (mode == 1 && dq.size() <= 10) begin
                #2;
                rst = 1'b1;
                #1;
                chk("abort_dump_valid_lat1", dump_valid_a, 0);
                chk("abort_dump_valid_lat3", dump_valid_b, 0);
                chk("abort_busy_lat1", busy_a, 0);
                chk("abort_busy_lat3", busy_b, 0);
                dq.delete();
                dump_ready = 1'b0;
                @(posedge clk); #1;
                rst       = 1'b0;
                oob_exp   = 1'b0;
                model_run = 1'b1;
                return;
            end
        end
        ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; we1 = 1'b0;
        dump_ready = 1'b0;
        chk("dump_words_left", dq.size(), 0);
        chk("dump_busy_fall", busy_a, 0);
        chk("dump_valid_fall", dump_valid_a, 0);
        chk("dump_busy_fall_lat3", busy_b, 0);
        if (mode == 2) chk("dump_stream_cycles", it, 17);
        model_run = 1'b1;
    endtask

    task automatic monitor_step();
        logic [31:0] dv [4];
        exp_t        e;
        logic [31:0] w;
        dv[0] = din0_a; dv[1] = din1_a; dv[2] = din0_b; dv[3] = din1_b;
        for (int p = 0; p < 4; p++) begin
            while (pq[p].size() > 0 && pq[p][0].due <= edges) begin
                e = pq[p].pop_front();
                chk(pname[p], dv[p], e.data);
            end
        end
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("dump_hold_valid", dump_valid_a, 1);
                chk("dump_hold_data", dump_data_a, stall_data);
            end
            if (dump_valid_a && dump_ready) begin
                if (dq.size() == 0) begin
                    chk("dump_extra_word", dump_valid_a, 0);
                end else begin
                    w = dq.pop_front();
                    chk("dump_data_lat1", dump_data_a, w);
                    chk("dump_data_lat3", dump_data_b, w);
                    chk("dump_valid_lat3", dump_valid_b, 1);
                end
            end
            stall_prev = dump_valid_a && !dump_ready;
            stall_data = dump_data_a;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ce0 = 1'b0; we0 = 1'b0; address0 = '0; dout0 = '0;
        ce1 = 1'b0; we1 = 1'b0; address1 = '0; dout1 = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        model_run = 1'b1;
        oob_exp   = 1'b0;
        #12;
        chk("rst_din0", din0_a, 0);
        chk("rst_din1", din1_a, 0);
        chk("rst_dump_data", dump_data_a, 0);
        chk("rst_load_ready", load_ready_a, 0);
        chk("rst_dump_valid", dump_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_oob", oob_a, 0);
        chk("rst_din1_lat3", din1_b, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_load(0);
        port_cycle(1, 0, 5, 0, 0, 0, 0, 0);
        port_cycle(0, 0, 0, 0, 1, 0, 0, 0);
        port_cycle(0, 0, 0, 0, 1, 0, 1, 0);
        port_cycle(0, 0, 0, 0, 1, 0, 2, 0);
        idle(4);
        port_cycle(1, 0, 4, 0, 1, 1, 4, 32'hAA);
        port_cycle(1, 0, 4, 0, 0, 0, 0, 0);
        port_cycle(1, 1, 7, 32'h11, 1, 1, 7, 32'h22);
        port_cycle(1, 0, 7, 0, 1, 0, 7, 0);
        idle(4);
        chk("oob_clear_before", oob_a, oob_exp);
        port_cycle(1, 0, 16, 0, 0, 0, 0, 0);
        port_cycle(0, 0, 0, 0, 1, 1, 12'h100, 32'h55);
        port_cycle(1, 0, 0, 0, 1, 0, 0, 0);
        idle(4);
        chk("oob_set_lat1", oob_a, oob_exp);
        chk("oob_set_lat3", oob_b, oob_exp);

        random_traffic(300);
        idle(4);
        chk("oob_sticky", oob_a, oob_exp);

        do_load(1);
        random_traffic(200);
        idle(4);

        do_dump(0);
        do_dump(1);
        chk("post_rst_din0", din0_a, 0);
        chk("post_rst_din1_lat3", din1_b, 0);
        chk("post_rst_oob", oob_a, oob_exp);
        do_dump(2);
        port_cycle(1, 0, 3, 0, 1, 0, 0, 0);
        idle(4);
        chk("final_oob_lat1", oob_a, oob_exp);
        chk("final_oob_lat3", oob_b, oob_exp);
        chk("port_queue_left", pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
